adc_sample_capture: RTL and testbench
=====================================

Name: adc_sample_capture

Overview:
Upstream acquisition stage that feeds the moving-average filter. It paces conversions of an external serial ADC with a programmable sample-period tick, and drives CS_n/SCLK to shift one 16-bit word MSB-first. Each completed word is presented on `sample` with a one-cycle `sample_valid` strobe, which is wired directly to the filter's `din`/`data_refresh`. Overruns are flagged.

Parameters:
- DATA_W, 16: bits per ADC word and width of `sample`.
- CLK_DIV, 4: clk cycles per SCLK half-period; must be >= 1.
- SAMPLE_PERIOD, 1000: clk cycles between sample ticks; must be >= 2*DATA_W*CLK_DIV+3.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run control; low stops ticks and aborts any frame.
- adc_sdo  in  1  ADC serial data, MSB first.
- ovr_clear  in  1  single-cycle clear of `overrun`.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock; idle low.
- sample  out  DATA_W  last completed word; held between strobes.
- sample_valid  out  1  one-cycle strobe when `sample` updates.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, sample=0, sample_valid=0, busy=0, overrun=0. The tick counter is 0 and the FSM is in IDLE.
- Tick counter:
  - Runs only while enable=1.
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - `tick` is asserted in the cycle the counter equals SAMPLE_PERIOD-1.
  - enable=0 clears the counter to 0, so the first tick comes SAMPLE_PERIOD cycles after enable rises.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: cs_n=1, sclk=0. On tick, go to SHIFT: cs_n=0, bit index=DATA_W-1, phase counter=0, busy=1.
  - SHIFT low phase: sclk=0 for CLK_DIV cycles.
  - SHIFT high phase: sclk=1 for CLK_DIV cycles.
  - adc_sdo is captured into the shift register on the clk edge that drives sclk 0->1.
  - After the high phase of bit 0: sclk=0, cs_n=1, go to DONE.
  - DONE: for one cycle, sample <= shift register, sample_valid=1, busy=0; then return to IDLE.
- Latency: sample_valid is asserted exactly 2*DATA_W*CLK_DIV+1 cycles after the tick cycle. The frame occupies cs_n low for 2*DATA_W*CLK_DIV cycles.
- Overrun:
  - A tick in SHIFT or DONE is dropped. overrun <= 1 and the current frame is unaffected.
  - ovr_clear sets overrun=0.
  - If ovr_clear and a dropping tick occur in the same cycle, set wins (overrun=1).
- enable falling mid-frame:
  - Next cycle: cs_n=1, sclk=0, busy=0, FSM=IDLE.
  - No sample_valid is issued and `sample` keeps its old value.
  - overrun is preserved.
- rst asserted mid-frame: all outputs return to reset values on the next edge; no partial word is emitted.
- sample_valid is never high in two consecutive cycles. sclk never toggles while cs_n=1.

Decomposition:
- Package `adc_cap_pkg`:
  - state enum `cap_state_t` {IDLE, SHIFT, DONE}.
  - localparam FRAME_CYCLES = 2*DATA_W*CLK_DIV.
  - width helper for the tick counter, $clog2(SAMPLE_PERIOD).
- Sub-module `sample_tick_gen`: enable-gated period counter producing `tick`, with parameter SAMPLE_PERIOD.
- The FSM, SCLK phase counter, shift register and overrun flag stay in the top module.

Test Plan (CLK_DIV=2, SAMPLE_PERIOD=80, DATA_W=16; the bench ADC model shifts its word on SCLK falling edges):
- Reset: hold rst=1 for 3 cycles with enable=1. Required: cs_n=1, sclk=0, sample=0, valid=0 throughout; first tick 80 cycles after rst drops.
- Single frame: ADC word 16'hA5C3. Required: cs_n low for exactly 64 cycles with 16 SCLK pulses of 2-high/2-low; sample=16'hA5C3 and valid high for 1 cycle, 65 cycles after the tick.
- Back-to-back: words 0x0001, 0x8000, 0xFFFF. Required: three strobes spaced 80 cycles apart with matching sample values; overrun stays 0.
- Overrun: SAMPLE_PERIOD=60 build. Required: overrun=1 after the second tick; the first frame completes correctly; ovr_clear pulse returns overrun to 0. A clear coincident with a dropped tick leaves overrun=1.
- Enable abort: drop enable after SCLK pulse 5. Required: cs_n=1 and sclk=0 next cycle, no strobe, sample unchanged; re-enable and the next tick comes 80 cycles later.
- Mid-frame reset: rst pulse at SCLK pulse 10. Required: all outputs at reset values next cycle, sample=0, no strobe.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and sizing helpers for the ADC sample capture block
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cap_state_t;

    localparam int DATA_W_DEF   = 16;
    localparam int CLK_DIV_DEF  = 4;
    localparam int FRAME_CYCLES = 2 * DATA_W_DEF * CLK_DIV_DEF;

    function automatic int frame_cycles(input int data_w, input int clk_div);
        return 2 * data_w * clk_div;
    endfunction

    function automatic int tick_cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - enable-gated sample period counter producing a one-cycle tick
module sample_tick_gen
    import adc_cap_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int TICK_W = tick_cnt_width(SAMPLE_PERIOD);
    localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(SAMPLE_PERIOD - 1);

    logic [TICK_W-1:0] cnt;

    // Holding the count at zero while disabled makes the first tick land a full period after enable.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - paced serial ADC frame capture with sample strobe and overrun flag
module adc_sample_capture
    import adc_cap_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_sdo,
    input  logic              ovr_clear,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0]  PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(DATA_W - 1);

    cap_state_t        state;
    logic              tick;
    logic [BIT_W-1:0]  bit_idx;
    logic [PH_W-1:0]   phase;
    logic [DATA_W-1:0] shift_reg;

    sample_tick_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            bit_idx      <= '0;
            phase        <= '0;
            shift_reg    <= '0;
        end else begin
            sample_valid <= 1'b0;

            // A dropped tick takes priority over a coincident clear.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end else if (ovr_clear) begin
                overrun <= 1'b0;
            end

            if (!enable) begin
                state    <= IDLE;
                adc_cs_n <= 1'b1;
                adc_sclk <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick) begin
                            state    <= SHIFT;
                            adc_cs_n <= 1'b0;
                            bit_idx  <= BIT_MSB;
                            phase    <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        // Data is taken on the edge that raises SCLK; the ADC changes it on the falling edge.
                        if (phase == PH_RISE) begin
                            adc_sclk  <= 1'b1;
                            shift_reg <= {shift_reg[DATA_W-2:0], adc_sdo};
                        end
                        if (phase == PH_LAST) begin
                            adc_sclk <= 1'b0;
                            phase    <= '0;
                            if (bit_idx == '0) begin
                                adc_cs_n     <= 1'b1;
                                state        <= DONE;
                                sample       <= shift_reg;
                                sample_valid <= 1'b1;
                                busy         <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx - 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb/tb_adc_sample_capture.sv - self-checking bench for adc_sample_capture
module tb_adc_sample_capture;

    localparam int DW = 16;
    localparam int CD = 2;
    localparam int FR = 2 * DW * CD;

    int per [2];

    logic        clk = 1'b0;
    logic        rst [2];
    logic        en [2];
    logic        clr [2];
    logic        sdo [2];
    logic        cs_n [2];
    logic        sclk [2];
    logic        vld [2];
    logic        busy [2];
    logic        ovr [2];
    logic [15:0] smp [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] adc_word [2];
    int          adc_bit [2];
    logic        prev_cs [2];
    logic        prev_sclk [2];

    bit          m_in [2];
    int          m_pos [2];
    bit          m_done [2];
    bit          m_ovr [2];
    int          m_age [2];
    logic [15:0] m_smp [2];
    logic [15:0] m_word [2];

    int          vld_n [2];
    int          last_vld_cyc [2];
    int          prev_vld_cyc [2];
    int          run [2];
    int          pulses [2];
    int          last_run [2];
    int          last_pulses [2];

    typedef struct {
        bit          rst;
        bit          en;
        int          n;
        bit          cs;
        bit          sclk;
        bit          vld;
        bit          busy;
        logic [15:0] smp;
    } row_t;

    row_t rows [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adc_sample_capture #(.DATA_W(16), .CLK_DIV(2), .SAMPLE_PERIOD(80)) dut0 (
        .clk(clk), .rst(rst[0]), .enable(en[0]), .adc_sdo(sdo[0]), .ovr_clear(clr[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample(smp[0]), .sample_valid(vld[0]),
        .busy(busy[0]), .overrun(ovr[0])
    );

    adc_sample_capture #(.DATA_W(16), .CLK_DIV(2), .SAMPLE_PERIOD(60)) dut1 (
        .clk(clk), .rst(rst[1]), .enable(en[1]), .adc_sdo(sdo[1]), .ovr_clear(clr[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample(smp[1]), .sample_valid(vld[1]),
        .busy(busy[1]), .overrun(ovr[1])
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic wait_vld(input int i, input int n0, input int budget);
        int k = 0;
        while (vld_n[i] == n0 && k < budget) begin
            step(1);
            k++;
        end
        chk("strobe_seen", i, 32'(vld_n[i] != n0), 1);
    endtask

    task automatic wait_pulses(input int i, input int n, input int budget);
        int k = 0;
        while (!(!cs_n[i] && pulses[i] >= n && !sclk[i]) && k < budget) begin
            step(1);
            k++;
        end
        chk("pulse_reached", i, 32'(k < budget), 1);
    endtask

    // Reference model: outputs predicted from the frame position, plus a serial ADC driving sdo.
    always @(negedge clk) begin : monitor
        bit tk, set_o, nd;
        for (int i = 0; i < 2; i++) begin
            chk("cs_n", i, cs_n[i], !m_in[i]);
            chk("sclk", i, sclk[i], m_in[i] && (((m_pos[i] / CD) % 2) == 1));
            chk("busy", i, busy[i], m_in[i]);
            chk("valid", i, vld[i], m_done[i]);
            chk("sample", i, smp[i], m_smp[i]);
            chk("overrun", i, ovr[i], m_ovr[i]);

            if (vld[i] === 1'b1) begin
                vld_n[i]++;
                prev_vld_cyc[i] = last_vld_cyc[i];
                last_vld_cyc[i] = cyc;
            end
            if (cs_n[i] === 1'b0) begin
                run[i]++;
                if (sclk[i] === 1'b1 && prev_sclk[i] === 1'b0) pulses[i]++;
            end else if (prev_cs[i] === 1'b0) begin
                last_run[i]    = run[i];
                last_pulses[i] = pulses[i];
                run[i]         = 0;
                pulses[i]      = 0;
            end

            if (prev_cs[i] === 1'b1 && cs_n[i] === 1'b0) adc_bit[i] = DW - 1;
            else if (cs_n[i] === 1'b0 && prev_sclk[i] === 1'b1 && sclk[i] === 1'b0) adc_bit[i]--;
            sdo[i]       = (cs_n[i] === 1'b0 && adc_bit[i] >= 0) ? adc_word[i][adc_bit[i]] : 1'b0;
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];

            if (rst[i]) begin
                m_in[i] = 0; m_pos[i] = 0; m_done[i] = 0; m_ovr[i] = 0; m_age[i] = 0; m_smp[i] = '0;
            end else begin
                tk    = en[i] && ((m_age[i] % per[i]) == per[i] - 1);
                set_o = tk && (m_in[i] || m_done[i]);
                nd    = 0;
                if (!en[i]) begin
                    m_in[i]  = 0;
                    m_age[i] = 0;
                end else begin
                    m_age[i]++;
                    if (m_in[i]) begin
                        if (m_pos[i] == FR - 1) begin
                            m_in[i]  = 0;
                            nd       = 1;
                            m_smp[i] = m_word[i];
                        end else begin
                            m_pos[i]++;
                        end
                    end else if (tk && !m_done[i]) begin
                        m_in[i]   = 1;
                        m_pos[i]  = 0;
                        m_word[i] = adc_word[i];
                    end
                end
                m_done[i] = nd;
                if (set_o) m_ovr[i] = 1;
                else if (clr[i]) m_ovr[i] = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] words [3];
        logic [15:0] sv;
        int n0, r, d0;

        per[0] = 80;
        per[1] = 60;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; en[i] = 0; clr[i] = 0; sdo[i] = 0; adc_word[i] = '0; adc_bit[i] = -1;
            prev_cs[i] = 1; prev_sclk[i] = 0;
            m_in[i] = 0; m_pos[i] = 0; m_done[i] = 0; m_ovr[i] = 0; m_age[i] = 0;
            m_smp[i] = '0; m_word[i] = '0;
            vld_n[i] = 0; last_vld_cyc[i] = 0; prev_vld_cyc[i] = 0;
            run[i] = 0; pulses[i] = 0; last_run[i] = 0; last_pulses[i] = 0;
        end

        rows[0] = '{1, 1, 3,  1, 0, 0, 0, 16'h0000};
        rows[1] = '{0, 1, 79, 1, 0, 0, 0, 16'h0000};
        rows[2] = '{0, 1, 1,  0, 0, 0, 1, 16'h0000};
        rows[3] = '{0, 1, 2,  0, 1, 0, 1, 16'h0000};
        rows[4] = '{0, 1, 61, 0, 1, 0, 1, 16'h0000};
        rows[5] = '{0, 1, 1,  1, 0, 1, 0, 16'hA5C3};
        rows[6] = '{0, 1, 1,  1, 0, 0, 0, 16'hA5C3};

        adc_word[0] = 16'hA5C3;
        step(1);
        foreach (rows[k]) begin
            rst[0] = rows[k].rst;
            en[0]  = rows[k].en;
            step(rows[k].n);
            chk("row_cs_n", k, cs_n[0], rows[k].cs);
            chk("row_sclk", k, sclk[0], rows[k].sclk);
            chk("row_valid", k, vld[0], rows[k].vld);
            chk("row_busy", k, busy[0], rows[k].busy);
            chk("row_sample", k, smp[0], rows[k].smp);
        end
        chk("cs_low_cycles", 0, last_run[0], FR);
        chk("sclk_pulses", 0, last_pulses[0], DW);

        words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
        foreach (words[k]) begin
            adc_word[0] = words[k];
            n0 = vld_n[0];
            wait_vld(0, n0, 100);
            chk("b2b_sample", k, smp[0], words[k]);
            chk("b2b_spacing", k, last_vld_cyc[0] - prev_vld_cyc[0], 80);
            chk("b2b_overrun", k, ovr[0], 0);
        end

        adc_word[0] = 16'h1234;
        wait_pulses(0, 5, 200);
        sv = smp[0];
        n0 = vld_n[0];
        en[0] = 0;
        step(1);
        chk("abort_cs_n", 0, cs_n[0], 1);
        chk("abort_sclk", 0, sclk[0], 0);
        chk("abort_busy", 0, busy[0], 0);
        step(1);
        en[0] = 1;
        r = cyc;
        step(79);
        chk("abort_no_strobe", 0, vld_n[0], n0);
        chk("abort_sample_kept", 0, smp[0], sv);
        chk("reenable_cs_before", 0, cs_n[0], 1);
        step(1);
        chk("reenable_tick_delay", 0, cyc - r, 80);
        chk("reenable_cs_after", 0, cs_n[0], 0);
        wait_vld(0, n0, 100);
        chk("reenable_sample", 0, smp[0], 16'h1234);

        adc_word[0] = 16'h0F0F;
        wait_pulses(0, 10, 200);
        n0 = vld_n[0];
        rst[0] = 1;
        step(1);
        rst[0] = 0;
        chk("midrst_cs_n", 0, cs_n[0], 1);
        chk("midrst_sclk", 0, sclk[0], 0);
        chk("midrst_sample", 0, smp[0], 0);
        chk("midrst_busy", 0, busy[0], 0);
        chk("midrst_valid", 0, vld[0], 0);
        step(30);
        chk("midrst_no_strobe", 0, vld_n[0], n0);

        adc_word[1] = 16'h3C5A;
        rst[1] = 0;
        en[1] = 1;
        d0 = cyc;
        goto_cyc(d0 + 119);
        chk("ovr_before_drop", 1, ovr[1], 0);
        step(1);
        chk("ovr_after_drop", 1, ovr[1], 1);
        wait_vld(1, 0, 100);
        chk("ovr_first_sample", 1, smp[1], 16'h3C5A);
        goto_cyc(d0 + 130);
        adc_word[1] = 16'hC3A5;
        clr[1] = 1;
        step(1);
        clr[1] = 0;
        chk("ovr_cleared", 1, ovr[1], 0);
        goto_cyc(d0 + 239);
        clr[1] = 1;
        step(1);
        clr[1] = 0;
        chk("ovr_set_wins", 1, ovr[1], 1);
        wait_vld(1, 1, 100);
        chk("ovr_third_sample", 1, smp[1], 16'hC3A5);

        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!en[i]) begin
                    if ($urandom_range(0, 3) == 0) en[i] = 1;
                end else if ($urandom_range(0, 299) == 0) begin
                    en[i] = 0;
                end
                clr[i] = ($urandom_range(0, 19) == 0);
                rst[i] = ($urandom_range(0, 799) == 0);
                if (!m_in[i]) adc_word[i] = 16'($urandom);
            end
            step(1);
        end

        for (int i = 0; i < 2; i++) begin
            rst[i] = 0;
            clr[i] = 0;
        end
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
